// File: rtl/maxpool2d_stream.sv
// ---------------------------------------------------------------------------
// maxpool2d_stream
//
// Streaming 2x2, stride-2 max pooling over a raster-ordered feature map.
// All channels of one pixel arrive packed in a single beat. Odd trailing
// rows/columns are dropped (floor semantics).
//
// Handshake: there is no backpressure. Every cycle with i_valid=1 is one
// accepted input pixel. o_valid is a one-cycle pulse per pooled pixel, and
// o_data is only meaningful when o_valid=1 (it holds its last value
// otherwise). o_last marks the final pooled pixel of a frame.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   i_data   in   input pixel, lane c at [DATA_WIDTH*c +: DATA_WIDTH]
//   i_valid  in   i_data valid this cycle
//   o_data   out  pooled pixel, same lane packing
//   o_valid  out  one-cycle pulse per pooled pixel
//   o_last   out  with o_valid on the last pooled pixel of a frame
// ---------------------------------------------------------------------------
module maxpool2d_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNEL    = 4,
    parameter int IN_WIDTH   = 5,
    parameter int IN_HEIGHT  = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH*CHANNEL-1:0] i_data,
    input  logic                          i_valid,
    output logic [DATA_WIDTH*CHANNEL-1:0] o_data,
    output logic                          o_valid,
    output logic                          o_last
);

    localparam int OUT_WIDTH  = IN_WIDTH / 2;
    localparam int OUT_HEIGHT = IN_HEIGHT / 2;
    localparam int DW         = DATA_WIDTH * CHANNEL;
    localparam int CW         = $clog2(IN_WIDTH);
    localparam int RW         = $clog2(IN_HEIGHT);
    localparam int LBW        = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    localparam logic [CW-1:0] COL_MAX     = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX     = RW'(IN_HEIGHT - 1);
    localparam logic [CW-1:0] COL_WIN_MAX = CW'(2 * OUT_WIDTH - 1);
    localparam logic [RW-1:0] ROW_WIN_MAX = RW'(2 * OUT_HEIGHT - 1);

    // Lane-wise unsigned max; the result is always one of the two inputs.
    function automatic logic [DW-1:0] lane_max(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNEL; c++) begin
            r[DATA_WIDTH*c +: DATA_WIDTH] =
                (a[DATA_WIDTH*c +: DATA_WIDTH] > b[DATA_WIDTH*c +: DATA_WIDTH]) ?
                a[DATA_WIDTH*c +: DATA_WIDTH] : b[DATA_WIDTH*c +: DATA_WIDTH];
        end
        return r;
    endfunction

    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [DW-1:0]  h_q, h_d;
    logic [DW-1:0]  lb_q [OUT_WIDTH];
    logic [DW-1:0]  lb_d [OUT_WIDTH];
    logic [DW-1:0]  o_data_q, o_data_d;
    logic           o_valid_q, o_valid_d;
    logic           o_last_q, o_last_d;

    logic           in_win;
    logic [LBW-1:0] lb_idx;

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        h_d       = h_q;
        lb_d      = lb_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;

        in_win = (col_q <= COL_WIN_MAX) && (row_q <= ROW_WIN_MAX);
        lb_idx = LBW'(col_q >> 1);

        if (i_valid) begin
            // Raster counters; the frame wraps with no idle cycle.
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (in_win) begin
                if (!col_q[0]) begin
                    // Left pixel of a horizontal pair, either row parity.
                    h_d = i_data;
                end else if (!row_q[0]) begin
                    // Top row of the window: park the pair max for the row below.
                    lb_d[lb_idx] = lane_max(h_q, i_data);
                end else begin
                    // Bottom-right pixel completes the window. lb[k] is read here
                    // before the next even row overwrites it, so no bypass needed.
                    o_data_d  = lane_max(lane_max(h_q, i_data), lb_q[lb_idx]);
                    o_valid_d = 1'b1;
                    o_last_d  = (row_q == ROW_WIN_MAX) && (col_q == COL_WIN_MAX);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            h_q       <= '0;
            for (int k = 0; k < OUT_WIDTH; k++) begin
                lb_q[k] <= '0;
            end
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            h_q       <= h_d;
            lb_q      <= lb_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;

endmodule
